// File: rtl/fir_xifu_pkg.sv
// Shared types and constants for the FIR XIFU controller.
//   X_ID_WIDTH / NB_ID : id width and number of tracked ids
//   sb_state_e         : per-id scoreboard state
//   ctrl2wb_t          : per-id issue/commit/kill vectors towards WB
//   wb2ctrl_t          : per-id retire clear from WB
package fir_xifu_pkg;

  localparam int unsigned X_ID_WIDTH = 4;
  localparam int unsigned NB_ID      = 2 ** X_ID_WIDTH;

  typedef enum logic [1:0] {
    SB_FREE,
    SB_ISSUED,
    SB_COMMITTED,
    SB_KILLED
  } sb_state_e;

  typedef struct packed {
    logic [NB_ID-1:0] issue;
    logic [NB_ID-1:0] commit;
    logic [NB_ID-1:0] kill;
  } ctrl2wb_t;

  typedef struct packed {
    logic [NB_ID-1:0] clear;
  } wb2ctrl_t;

  function automatic int unsigned popcount(input logic [NB_ID-1:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < int'(NB_ID); i++) begin
      c += 32'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/fir_xifu_ctrl_sb_entry.sv
// Single-id scoreboard entry FSM.
//   issue_i    : issue fire addressed to this id
//   commit_i   : non-kill commit addressed to this id
//   kill_i     : kill commit addressed to this id
//   clear_i    : WB retire clear for this id
//   issue_o    : registered, entry ISSUED or COMMITTED
//   commit_o   : registered, entry COMMITTED
//   kill_o     : registered, entry KILLED
//   free_o     : entry FREE (decoded from state register)
//   release_o  : entry leaves the live set at the coming edge
module fir_xifu_sb_entry
  import fir_xifu_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic issue_i,
  input  logic commit_i,
  input  logic kill_i,
  input  logic clear_i,
  output logic issue_o,
  output logic commit_o,
  output logic kill_o,
  output logic free_o,
  output logic release_o
);

  sb_state_e state_q, state_d;
  logic      issue_q, commit_q, kill_q;

  always_comb begin
    state_d   = state_q;
    release_o = 1'b0;
    unique case (state_q)
      SB_FREE: begin
        if (issue_i) state_d = SB_ISSUED;
      end
      SB_ISSUED: begin
        if (kill_i) begin
          state_d   = SB_KILLED;
          release_o = 1'b1;
        end else if (commit_i) begin
          state_d = SB_COMMITTED;
        end
      end
      SB_COMMITTED: begin
        // Kill takes priority over a same-cycle retire clear.
        if (kill_i) begin
          state_d   = SB_KILLED;
          release_o = 1'b1;
        end else if (clear_i) begin
          state_d   = SB_FREE;
          release_o = 1'b1;
        end
      end
      SB_KILLED: state_d = SB_FREE;
      default:   state_d = SB_FREE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= SB_FREE;
      issue_q  <= 1'b0;
      commit_q <= 1'b0;
      kill_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      issue_q  <= (state_d == SB_ISSUED) || (state_d == SB_COMMITTED);
      commit_q <= (state_d == SB_COMMITTED);
      kill_q   <= (state_d == SB_KILLED);
    end
  end

  assign issue_o  = issue_q;
  assign commit_o = commit_q;
  assign kill_o   = kill_q;
  assign free_o   = (state_q == SB_FREE);

endmodule

// File: rtl/fir_xifu_ctrl.sv
// Scoreboard/controller for the FIR XIFU pipeline.
//   issue_*         : XIF issue handshake; issue_ready_o throttles new ids
//   commit_*        : XIF commit channel (commit or kill per id)
//   wb_clear_i      : one-hot retire clear from WB
//   ctrl2wb_*_o     : registered per-id issue/commit/kill vectors
//   outstanding_o   : number of ISSUED/COMMITTED entries
//   flush_o         : high while any entry is KILLED
module fir_xifu_ctrl
  import fir_xifu_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 4,
  localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  issue_valid_i,
  input  logic                  issue_accept_i,
  input  logic [X_ID_WIDTH-1:0] issue_id_i,
  output logic                  issue_ready_o,
  input  logic                  commit_valid_i,
  input  logic [X_ID_WIDTH-1:0] commit_id_i,
  input  logic                  commit_kill_i,
  input  logic [NB_ID-1:0]      wb_clear_i,
  output logic [NB_ID-1:0]      ctrl2wb_issue_o,
  output logic [NB_ID-1:0]      ctrl2wb_commit_o,
  output logic [NB_ID-1:0]      ctrl2wb_kill_o,
  output logic [CntW-1:0]       outstanding_o,
  output logic                  flush_o
);

  ctrl2wb_t         ctrl2wb;
  wb2ctrl_t         wb2ctrl;
  logic [NB_ID-1:0] free_vec;
  logic [NB_ID-1:0] release_vec;
  logic             issue_fire;
  logic [CntW-1:0]  outstanding_q, outstanding_d;
  int               cnt_next;

  assign wb2ctrl.clear = wb_clear_i;
  assign issue_fire    = issue_valid_i & issue_accept_i & issue_ready_o;

  for (genvar g = 0; g < int'(NB_ID); g++) begin : gen_entry
    fir_xifu_sb_entry u_entry (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .issue_i   (issue_fire & (issue_id_i == X_ID_WIDTH'(g))),
      .commit_i  (commit_valid_i & (commit_id_i == X_ID_WIDTH'(g)) & ~commit_kill_i),
      .kill_i    (commit_valid_i & (commit_id_i == X_ID_WIDTH'(g)) & commit_kill_i),
      .clear_i   (wb2ctrl.clear[g]),
      .issue_o   (ctrl2wb.issue[g]),
      .commit_o  (ctrl2wb.commit[g]),
      .kill_o    (ctrl2wb.kill[g]),
      .free_o    (free_vec[g]),
      .release_o (release_vec[g])
    );
  end

  // Several entries may retire in one cycle (multi-bit clear plus a kill).
  always_comb begin
    cnt_next = int'(outstanding_q) + int'(issue_fire) - int'(popcount(release_vec));
    if (cnt_next < 0) begin
      outstanding_d = '0;
    end else if (cnt_next > int'(MAX_OUTSTANDING)) begin
      outstanding_d = CntW'(MAX_OUTSTANDING);
    end else begin
      outstanding_d = CntW'(cnt_next);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) outstanding_q <= '0;
    else       outstanding_q <= outstanding_d;
  end

  assign issue_ready_o    = (int'(outstanding_q) < int'(MAX_OUTSTANDING)) & free_vec[issue_id_i];
  assign ctrl2wb_issue_o  = ctrl2wb.issue;
  assign ctrl2wb_commit_o = ctrl2wb.commit;
  assign ctrl2wb_kill_o   = ctrl2wb.kill;
  assign outstanding_o    = outstanding_q;
  assign flush_o          = |ctrl2wb.kill;

endmodule

// File: tb/tb_fir_xifu_ctrl.sv
// Scoreboard bench for fir_xifu_ctrl: a per-id state model predicts outputs,
// a monitor process pops and compares them against the DUT.
module tb_fir_xifu_ctrl;

  localparam int NID  = 16;
  localparam int MAXO = 4;
  localparam int OW   = 3;

  localparam int ST_FREE = 0;
  localparam int ST_ISS  = 1;
  localparam int ST_COM  = 2;
  localparam int ST_KIL  = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            issue_valid, issue_accept, issue_ready;
  logic [3:0]      issue_id;
  logic            commit_valid, commit_kill;
  logic [3:0]      commit_id;
  logic [NID-1:0]  wb_clear;
  logic [NID-1:0]  o_issue, o_commit, o_kill;
  logic [OW-1:0]   outstanding;
  logic            flush;

  fir_xifu_ctrl #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .issue_valid_i    (issue_valid),
    .issue_accept_i   (issue_accept),
    .issue_id_i       (issue_id),
    .issue_ready_o    (issue_ready),
    .commit_valid_i   (commit_valid),
    .commit_id_i      (commit_id),
    .commit_kill_i    (commit_kill),
    .wb_clear_i       (wb_clear),
    .ctrl2wb_issue_o  (o_issue),
    .ctrl2wb_commit_o (o_commit),
    .ctrl2wb_kill_o   (o_kill),
    .outstanding_o    (outstanding),
    .flush_o          (flush)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NID-1:0] iss;
    logic [NID-1:0] com;
    logic [NID-1:0] kil;
    logic [OW-1:0]  cnt;
    logic           fl;
  } exp_t;

  exp_t exp_q[$];
  logic rdy_q[$];
  int   checks = 0;
  int   errors = 0;
  int   st[NID];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic int live_cnt();
    int c = 0;
    for (int i = 0; i < NID; i++) if (st[i] == ST_ISS || st[i] == ST_COM) c++;
    return c;
  endfunction

  function automatic exp_t snapshot();
    exp_t e;
    e = '0;
    for (int i = 0; i < NID; i++) begin
      e.iss[i] = (st[i] == ST_ISS) || (st[i] == ST_COM);
      e.com[i] = (st[i] == ST_COM);
      e.kil[i] = (st[i] == ST_KIL);
    end
    e.cnt = OW'(live_cnt());
    e.fl  = |e.kil;
    return e;
  endfunction

  // Drive one cycle of stimulus and predict readiness and the post-edge state.
  task automatic cycle(input logic v, input logic a, input int id, input logic cv,
                       input int cid, input logic k, input logic [NID-1:0] clr);
    logic er, fire;
    int   nxt[NID];
    @(negedge clk);
    issue_valid  = v;
    issue_accept = a;
    issue_id     = 4'(id);
    commit_valid = cv;
    commit_id    = 4'(cid);
    commit_kill  = k;
    wb_clear     = clr;
    er   = (live_cnt() < MAXO) && (st[id] == ST_FREE);
    fire = v && a && er;
    rdy_q.push_back(er);
    for (int i = 0; i < NID; i++) begin
      nxt[i] = st[i];
      case (st[i])
        ST_FREE: if (fire && id == i) nxt[i] = ST_ISS;
        ST_ISS:  if (cv && cid == i) nxt[i] = k ? ST_KIL : ST_COM;
        ST_COM: begin
          if (cv && cid == i && k) nxt[i] = ST_KIL;
          else if (clr[i])         nxt[i] = ST_FREE;
        end
        default: nxt[i] = ST_FREE;
      endcase
    end
    for (int i = 0; i < NID; i++) st[i] = nxt[i];
    exp_q.push_back(snapshot());
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 0, 1'b0, 0, 1'b0, '0);
  endtask

  task automatic issue(input int id);
    cycle(1'b1, 1'b1, id, 1'b0, 0, 1'b0, '0);
  endtask

  task automatic commit(input int id, input logic k);
    cycle(1'b0, 1'b0, 0, 1'b1, id, k, '0);
  endtask

  task automatic clear(input int id);
    cycle(1'b0, 1'b0, 0, 1'b0, 0, 1'b0, NID'(1) << id);
  endtask

  task automatic zero_inputs();
    issue_valid = 1'b0; issue_accept = 1'b0; issue_id = '0;
    commit_valid = 1'b0; commit_id = '0; commit_kill = 1'b0; wb_clear = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_issue"}, 64'(o_issue), 64'(0));
    chk({tag, "_commit"}, 64'(o_commit), 64'(0));
    chk({tag, "_kill"}, 64'(o_kill), 64'(0));
    chk({tag, "_cnt"}, 64'(outstanding), 64'(0));
    chk({tag, "_flush"}, 64'(flush), 64'(0));
    chk({tag, "_ready"}, 64'(issue_ready), 64'(1));
  endtask

  // Monitor: readiness is compared mid low phase, state just after the edge.
  initial begin
    exp_t e;
    logic r;
    forever begin
      @(negedge clk);
      #2;
      if (rdy_q.size() != 0) begin
        r = rdy_q.pop_front();
        chk("issue_ready", 64'(issue_ready), 64'(r));
      end
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("ctrl2wb_issue", 64'(o_issue), 64'(e.iss));
        chk("ctrl2wb_commit", 64'(o_commit), 64'(e.com));
        chk("ctrl2wb_kill", 64'(o_kill), 64'(e.kil));
        chk("outstanding", 64'(outstanding), 64'(e.cnt));
        chk("flush", 64'(flush), 64'(e.fl));
      end
    end
  end

  initial begin
    for (int i = 0; i < NID; i++) st[i] = ST_FREE;
    zero_inputs();
    rst = 1'b1;
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // Issue / commit / retire of a single id.
    issue(3); idle(); commit(3, 1'b0); clear(3); idle();

    // Fill to the outstanding limit, then a blocked fifth issue.
    issue(0); issue(1); issue(2); issue(3); issue(4);
    commit(0, 1'b0);
    cycle(1'b1, 1'b1, 4, 1'b0, 0, 1'b0, NID'(1) << 0);  // still blocked this cycle
    issue(4);                                             // slot freed by the clear

    // Kill path on a committed and an issued entry.
    commit(4, 1'b0); commit(4, 1'b1); idle();
    issue(5); commit(5, 1'b1); idle(); idle();

    // Ignored events: commit to FREE id, clear of ISSUED id, commit to KILLED id.
    commit(7, 1'b0); clear(2);
    commit(3, 1'b1); commit(3, 1'b0); idle();

    // Issue and clear of a different id in the same cycle.
    commit(1, 1'b0); idle();
    issue(0); commit(0, 1'b0);
    cycle(1'b1, 1'b1, 6, 1'b0, 0, 1'b0, NID'(1) << 0);

    // Kill and clear on the same committed id: kill wins.
    commit(1, 1'b0);
    cycle(1'b0, 1'b0, 0, 1'b1, 1, 1'b1, NID'(1) << 1);
    idle();

    // Asynchronous reset with live entries, applied between edges.
    issue(8); idle();
    @(posedge clk);
    #3;
    zero_inputs();
    rst = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    for (int i = 0; i < NID; i++) st[i] = ST_FREE;
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic over a small id range to force reuse and collisions.
    for (int n = 0; n < 600; n++) begin
      cycle(($urandom % 4) != 0, ($urandom % 4) != 0, int'($urandom_range(0, 7)),
            ($urandom % 2) != 0, int'($urandom_range(0, 7)), ($urandom % 5) == 0,
            NID'($urandom_range(0, 255) & $urandom_range(0, 255)));
    end

    for (int t = 0; t < 10 && (exp_q.size() != 0 || rdy_q.size() != 0); t++) begin
      @(posedge clk);
      #2;
    end
    chk("scoreboard_drained", 64'(exp_q.size() + rdy_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_xifu_ctrl.md
Name: fir_xifu_ctrl

Overview:
Scoreboard/controller for the FIR XIFU pipeline. It tracks every CV-X-IF instruction id through issue, commit, kill and write-back clear, and drives the per-id issue/commit/kill vectors consumed by the WB stage. It throttles new issues when the outstanding limit is reached and raises a pipeline flush on kill. It sits beside the decode/EX/WB stages and is fed by the XIF issue and commit channels plus the WB clear vector.

Parameters:
X_ID_WIDTH, 4, width of XIF instruction id
NB_ID, 2**X_ID_WIDTH, number of tracked ids (one entry per id)
MAX_OUTSTANDING, 4, max ids simultaneously in ISSUED/COMMITTED (1..NB_ID)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset
issue_valid_i  in  1  XIF issue_valid from core
issue_accept_i  in  1  decoder accepts the offered instruction (XFIR opcode)
issue_id_i  in  X_ID_WIDTH  id of offered instruction
issue_ready_o  out  1  controller can take a new id
commit_valid_i  in  1  XIF commit_valid
commit_id_i  in  X_ID_WIDTH  id being committed/killed
commit_kill_i  in  1  kill flag of commit transaction
wb_clear_i  in  NB_ID  one-hot clear from WB (instruction retired)
ctrl2wb_issue_o  out  NB_ID  entry is ISSUED or COMMITTED
ctrl2wb_commit_o  out  NB_ID  entry is COMMITTED
ctrl2wb_kill_o  out  NB_ID  entry is KILLED
outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  live entry count
flush_o  out  1  pipeline flush request

Behaviour:
- One clock clk_i; reset rst_i is asynchronous and active-high. On reset: all entries FREE, all outputs 0 except issue_ready_o=1.
- Per-entry FSM, states FREE, ISSUED, COMMITTED, KILLED:
  - FREE->ISSUED on issue fire (issue_valid_i & issue_accept_i & issue_ready_o & issue_id_i==id).
  - ISSUED->COMMITTED on commit_valid_i & commit_id_i==id & ~commit_kill_i.
  - ISSUED->KILLED, or COMMITTED->KILLED, on commit_valid_i & id match & commit_kill_i.
  - COMMITTED->FREE on wb_clear_i[id].
  - KILLED->FREE unconditionally the next cycle.
- Registered outputs: a transition at edge N is visible on ctrl2wb_* after edge N, with no combinational path from inputs to ctrl2wb_*.
- issue_ready_o = (outstanding_o < MAX_OUTSTANDING) & (entry[issue_id_i]==FREE). Combinational from issue_id_i only.
- outstanding_o counts entries in ISSUED or COMMITTED. Increment on issue fire, decrement on clear or kill. A simultaneous inc and dec leaves it unchanged. It saturates and never wraps; underflow is impossible by construction.
- flush_o is 1 for exactly one cycle, the cycle any entry is KILLED (OR of ctrl2wb_kill_o).
- Boundary rules:
  - Commit or kill for a FREE id: ignored.
  - Commit for a KILLED id: ignored.
  - wb_clear_i for an entry not COMMITTED: ignored.
  - Issue fire and clear of a different id in the same cycle: both take effect.
  - Issue to an id that is still live: blocked by issue_ready_o.
  - Kill and wb_clear_i on the same id in the same cycle: kill wins, and the entry goes KILLED.
  - Reset mid-operation: all entries return to FREE asynchronously and the counter clears.

Decomposition:
- fir_xifu_pkg holds:
  - ctrl2wb_t {issue, commit, kill: logic [NB_ID-1:0]} and wb2ctrl_t {clear}; the top-level ports pack into these.
  - sb_state_e enum {SB_FREE, SB_ISSUED, SB_COMMITTED, SB_KILLED}.
  - Constants X_ID_WIDTH and NB_ID.
- Sub-module fir_xifu_sb_entry: a single-id FSM, instantiated NB_ID times via generate. The parent holds the counter, the ready logic and the flush OR.

Test Plan:
- Reset, then issue id 3 with accept -> next cycle ctrl2wb_issue_o[3]=1, outstanding_o=1. Then commit id 3 (no kill) -> commit_o[3]=1. Then wb_clear_i[3] -> entry FREE, outstanding_o=0.
- Issue ids 0,1,2,3 back-to-back with MAX_OUTSTANDING=4 -> issue_ready_o=0 on the 5th attempt (id 4). Clear id 0 -> ready returns the following cycle.
- Issue id 5, commit id 5 with commit_kill_i=1 -> kill_o[5]=1 and flush_o=1 for exactly one cycle, then entry FREE and outstanding_o decremented.
- Commit id 7 while entry 7 is FREE, and wb_clear_i[2] while entry 2 is ISSUED -> no state change and outstanding_o unchanged.
- In the same cycle, issue id 1 and wb_clear_i[0] (entry 0 COMMITTED) -> entry 1 ISSUED, entry 0 FREE, outstanding_o unchanged.
- With 3 entries live, assert rst_i asynchronously between edges -> all ctrl2wb_* = 0, outstanding_o = 0 and issue_ready_o = 1 immediately.
